// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks the shared resource to one requester until it
// finishes, withdraws, or exceeds the hold limit; priority rotates after every release.
module rr_lock_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDW      = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic [IDW-1:0]     owner_id,
    output logic               timeout
);

    localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [IDW-1:0]     ptr_r, ptr_s;
    logic [HCW-1:0]     hold_r, hold_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_s;
    logic               busy_r, busy_s;
    logic [IDW-1:0]     owner_r, owner_s;
    logic               timeout_r, timeout_s;

    logic [IDW-1:0]     sel_s;
    logic [IDW-1:0]     idx_s;
    logic               found_s;

    // Rotating priority search: first asserted request at or after the pointer
    always_comb begin
        sel_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = ptr_r + IDW'(i);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic; every release leaves at least one idle cycle
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        hold_s    = hold_r;
        gnt_s     = gnt_r;
        busy_s    = busy_r;
        owner_s   = owner_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en && found_s) begin
                    state_s = ST_OWNED;
                    gnt_s   = NUM_REQ'(1) << sel_s;
                    owner_s = sel_s;
                    busy_s  = 1'b1;
                    hold_s  = '0;
                end else begin
                    gnt_s   = '0;
                    owner_s = '0;
                    busy_s  = 1'b0;
                end
            end
            ST_OWNED: begin
                if (done || !req[owner_r] || (hold_r == HOLD_LAST)) begin
                    state_s   = ST_IDLE;
                    gnt_s     = '0;
                    busy_s    = 1'b0;
                    owner_s   = '0;
                    hold_s    = '0;
                    ptr_s     = owner_r + IDW'(1);
                    // Done or withdrawal at the threshold still counts as a normal release
                    timeout_s = !done && req[owner_r];
                end else begin
                    hold_s = hold_r + HCW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = '0;
                busy_s  = 1'b0;
                owner_s = '0;
                hold_s  = '0;
            end
        endcase
    end

    // State and output registers; async reset drops the grant immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            hold_r    <= '0;
            gnt_r     <= '0;
            busy_r    <= 1'b0;
            owner_r   <= '0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            hold_r    <= hold_s;
            gnt_r     <= gnt_s;
            busy_r    <= busy_s;
            owner_r   <= owner_s;
            timeout_r <= timeout_s;
        end
    end

    assign gnt      = gnt_r;
    assign busy     = busy_r;
    assign owner_id = owner_r;
    assign timeout  = timeout_r;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: a transaction-level ownership model
// predicts every cycle's outputs, and a monitor compares them after each edge.
module tb_rr_lock_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_REQ-1:0] req   = '0;
    logic               done  = 1'b0;
    logic               en    = 1'b0;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic [IDW-1:0]     owner_id;
    logic               timeout;

    rr_lock_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clock(clock), .reset(reset), .req(req), .done(done), .en(en),
        .gnt(gnt), .busy(busy), .owner_id(owner_id), .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NUM_REQ-1:0] gnt;
        logic               busy;
        logic [IDW-1:0]     oid;
        logic               to;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   n_timeouts = 0;

    // Reference model: who owns the resource, for how many cycles, and whose turn is next
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic [NUM_REQ-1:0] r, input logic e, input logic d);
        exp_t x;
        x.to = 1'b0;
        if (m_owner < 0) begin
            if (e && r != '0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NUM_REQ;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_held = 1;
            end
        end else begin
            if (d || !r[m_owner] || m_held == MAX_HOLD) begin
                x.to    = !(d || !r[m_owner]);
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
            end
        end
        x.gnt  = (m_owner < 0) ? '0 : (NUM_REQ'(1) << m_owner);
        x.busy = (m_owner >= 0);
        x.oid  = (m_owner < 0) ? '0 : IDW'(m_owner);
        if (x.to) n_timeouts++;
        q.push_back(x);
    endtask

    task automatic step(input logic [NUM_REQ-1:0] r, input logic e, input logic d);
        @(negedge clock);
        req  = r;
        en   = e;
        done = d;
        model_step(r, e, d);
    endtask

    // Monitor: pops the prediction for the edge just taken and compares every output
    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("gnt", int'(gnt), int'(mon_e.gnt));
            chk("busy", int'(busy), int'(mon_e.busy));
            chk("owner_id", int'(owner_id), int'(mon_e.oid));
            chk("timeout", int'(timeout), int'(mon_e.to));
        end
    end

    logic [NUM_REQ-1:0] rnd_req;

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_owner", int'(owner_id), 0);
        chk("reset_timeout", int'(timeout), 0);
        reset = 1'b0;

        // 1: two requesters, done three cycles into the first grant
        step(4'b0101, 1'b1, 1'b0);
        step(4'b0101, 1'b1, 1'b0);
        step(4'b0101, 1'b1, 1'b0);
        step(4'b0101, 1'b1, 1'b1);
        repeat (4) step(4'b0101, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // 2: all requesting, each owner finishes on its second owned cycle
        repeat (5) begin
            step(4'b1111, 1'b1, 1'b0);
            step(4'b1111, 1'b1, 1'b0);
            step(4'b1111, 1'b1, 1'b1);
        end
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // 3: sole requester never finishes -> forced release and re-grant
        repeat (22) step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // 4: done exactly at the threshold, then a mid-ownership withdrawal
        repeat (8) step(4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b0);
        repeat (3) step(4'b1001, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        repeat (3) step(4'b1001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // 5: enable dropped while owner 3 holds; no grants until re-enabled
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        repeat (4) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b0);

        // 6: asynchronous reset between edges while requester 3 owns
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_gnt", int'(gnt), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_owner", int'(owner_id), 0);
        chk("async_timeout", int'(timeout), 0);
        #1;
        reset   = 1'b0;
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1);

        // Randomised traffic: sticky requests, occasional done and enable drops
        rnd_req = 4'($urandom);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < NUM_REQ; b++) begin
                if ($urandom_range(0, 9) == 0) rnd_req[b] = ~rnd_req[b];
            end
            step(rnd_req,
                 ($urandom_range(0, 7) != 0),
                 (cyc < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clock);
                #2;
                reset = 1'b1;
                #1;
                chk("rnd_async_gnt", int'(gnt), 0);
                #1;
                reset   = 1'b0;
                m_owner = -1;
                m_held  = 0;
                m_ptr   = 0;
            end
        end

        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        @(posedge clock);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        tests++;
        if (n_timeouts == 0) begin
            fails++;
            $display("FAIL timeout_seen: got %0d forced releases, expected at least 1", n_timeouts);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
